// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator: format codes,
// opcode constants and the elastic-buffer state encoding.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decode: format, extended immediate, pc+imm and
// the misalignment / illegal flags, packed as one entry vector.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int EN_ZICSR    = 1,
    parameter int EN_RV64_OPS = 0
) (
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    output logic [2*XLEN+4:0] entry
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       itype;
        logic [XLEN-1:0] target;
        logic            misalign;
        logic            illegal;
    } imm_entry_t;

    localparam bit RV64_OK = (EN_RV64_OPS != 0) && (XLEN == 64);

    imm_entry_t e;
    logic [31:0] imm32;

    always_comb begin
        e       = '0;
        imm32   = '0;
        e.itype = IMM_NONE;
        e.illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            e.illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: e.itype = IMM_I;
                OPC_SYSTEM: e.itype = ((EN_ZICSR != 0) && instr[14]) ? IMM_Z : IMM_I;
                OPC_STORE:  e.itype = IMM_S;
                OPC_BRANCH: e.itype = IMM_B;
                OPC_LUI, OPC_AUIPC: e.itype = IMM_U;
                OPC_JAL:    e.itype = IMM_J;
                OPC_OP:     e.itype = IMM_NONE;
                OPC_OP_IMM_32: begin
                    if (RV64_OK) e.itype = IMM_I;
                    else         e.illegal = 1'b1;
                end
                OPC_OP_32: begin
                    if (!RV64_OK) e.illegal = 1'b1;
                end
                default: e.illegal = 1'b1;
            endcase
        end

        // The Z immediate has bit 31 clear, so the shared sign-extension is harmless.
        case (e.itype)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z: imm32 = {27'b0, instr[19:15]};
            default: imm32 = '0;
        endcase

        e.imm      = XLEN'($signed(imm32));
        e.target   = pc + e.imm;
        e.misalign = ((e.itype == IMM_B) || (e.itype == IMM_J)) && (e.target[1:0] != 2'b00);
    end

    assign entry = e;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator wrapped in a two-entry elastic buffer (OUT + SKID)
// with registered outputs, registered in_ready and a synchronous flush.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int EN_ZICSR    = 1,
    parameter int EN_RV64_OPS = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_misalign,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       itype;
        logic [XLEN-1:0] target;
        logic            misalign;
        logic            illegal;
    } imm_entry_t;

    imm_entry_t  dec, out_q, skid_q;
    pipe_state_e state_q, state_n;
    logic        ready_q;
    logic        accept;
    logic        load_out_dec, load_out_skid, load_skid;

    imm_extract #(
        .XLEN        (XLEN),
        .EN_ZICSR    (EN_ZICSR),
        .EN_RV64_OPS (EN_RV64_OPS)
    ) u_extract (
        .instr (in_instr),
        .pc    (in_pc),
        .entry (dec)
    );

    assign accept = in_valid && ready_q;

    always_comb begin
        state_n       = state_q;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_out_dec = 1'b1;
                        state_n      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && out_ready) begin
                        load_out_dec = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_n   = ST_FULL;
                    end else if (out_ready) begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        load_out_skid = 1'b1;
                        state_n       = ST_ONE;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    // in_ready is its own flop so upstream never sees a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n != ST_FULL);
            if (load_out_dec)       out_q <= dec;
            else if (load_out_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= dec;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_imm      = out_q.imm;
    assign out_type     = out_q.itype;
    assign out_target   = out_q.target;
    assign out_misalign = out_q.misalign;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors on XLEN=32 and XLEN=64
// instances, then backpressure, flush and asynchronous reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [2:0]  out_type;
    logic        out_misalign, out_illegal;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64, out_imm64, out_target64;
    logic [2:0]  out_type64;
    logic        out_misalign64, out_illegal64;

    int vector_count = 0;
    int miss_count   = 0;

    imm_gen_pipe #(.XLEN(32), .EN_ZICSR(1), .EN_RV64_OPS(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
        .out_target(out_target), .out_misalign(out_misalign), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .EN_ZICSR(1), .EN_RV64_OPS(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64), .out_type(out_type64),
        .out_target(out_target64), .out_misalign(out_misalign64), .out_illegal(out_illegal64)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one instruction with out_ready high; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        in_instr  = instr;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus64(input logic [31:0] instr, input logic [63:0] pc);
        in_instr64  = instr;
        in_pc64     = pc;
        in_valid64  = 1'b1;
        out_ready64 = 1'b1;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
    endtask

    task automatic checkEntry(input string tag, input logic [31:0] imm, input logic [2:0] typ,
                              input logic [31:0] target, input logic mis, input logic ill);
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".imm"}, 64'(out_imm), 64'(imm));
        checkOutput({tag, ".type"}, 64'(out_type), 64'(typ));
        checkOutput({tag, ".target"}, 64'(out_target), 64'(target));
        checkOutput({tag, ".misalign"}, 64'(out_misalign), 64'(mis));
        checkOutput({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        in_valid64 = 1'b0; in_instr64 = '0; in_pc64 = '0; out_ready64 = 1'b0;

        #12;
        checkOutput("rst.valid", 64'(out_valid), 64'd0);
        checkOutput("rst.ready", 64'(in_ready), 64'd1);
        checkOutput("rst.imm", 64'(out_imm), 64'd0);
        checkOutput("rst.type", 64'(out_type), 64'd0);
        checkOutput("rst.target", 64'(out_target), 64'd0);
        checkOutput("rst.misalign", 64'(out_misalign), 64'd0);
        checkOutput("rst.illegal", 64'(out_illegal), 64'd0);
        checkOutput("rst.valid64", 64'(out_valid64), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Decode vectors: imm, type, target, misalign, illegal.
        applyStimulus(32'hFFF00093, 32'h0);        checkEntry("addi",  32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 1'b0, 1'b0);
        applyStimulus(32'hFE000EE3, 32'h100);      checkEntry("beq",   32'hFFFFFFFC, 3'd3, 32'h000000FC, 1'b0, 1'b0);
        applyStimulus(32'h0080006F, 32'h1000);     checkEntry("jal",   32'h00000008, 3'd5, 32'h00001008, 1'b0, 1'b0);
        applyStimulus(32'h0080006F, 32'h2);        checkEntry("jalmis",32'h00000008, 3'd5, 32'h0000000A, 1'b1, 1'b0);
        applyStimulus(32'h00100093, 32'h1);        checkEntry("imis",  32'h00000001, 3'd1, 32'h00000002, 1'b0, 1'b0);
        applyStimulus(32'h123450B7, 32'h0);        checkEntry("lui",   32'h12345000, 3'd4, 32'h12345000, 1'b0, 1'b0);
        applyStimulus(32'h3002D073, 32'h10);       checkEntry("csrrwi",32'h00000005, 3'd6, 32'h00000015, 1'b0, 1'b0);
        applyStimulus(32'hFE112C23, 32'h0);        checkEntry("sw",    32'hFFFFFFF8, 3'd2, 32'hFFFFFFF8, 1'b0, 1'b0);
        applyStimulus(32'h002081B3, 32'h20);       checkEntry("add",   32'h00000000, 3'd0, 32'h00000020, 1'b0, 1'b0);
        applyStimulus(32'h0000007F, 32'h40);       checkEntry("bad7f", 32'h00000000, 3'd0, 32'h00000040, 1'b0, 1'b1);
        applyStimulus(32'h00000001, 32'h0);        checkEntry("bad01", 32'h00000000, 3'd0, 32'h00000000, 1'b0, 1'b1);
        applyStimulus(32'h0010009B, 32'h0);        checkEntry("addiw32", 32'h00000000, 3'd0, 32'h00000000, 1'b0, 1'b1);
        applyStimulus(32'h00800093, 32'hFFFFFFFC); checkEntry("wrap",  32'h00000008, 3'd1, 32'h00000004, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("drain.valid", 64'(out_valid), 64'd0);

        applyStimulus64(32'h800000B7, 64'h0);
        checkOutput("lui64.imm", out_imm64, 64'hFFFFFFFF80000000);
        checkOutput("lui64.type", 64'(out_type64), 64'd4);
        applyStimulus64(32'h0010009B, 64'h0);
        checkOutput("addiw64.imm", out_imm64, 64'd1);
        checkOutput("addiw64.type", 64'(out_type64), 64'd1);
        checkOutput("addiw64.illegal", 64'(out_illegal64), 64'd0);
        @(posedge clk); #1;

        // Backpressure: three entries streamed against a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = '0;
        in_instr = 32'h00100093; @(posedge clk); #1;
        checkOutput("bp.ready1", 64'(in_ready), 64'd1);
        in_instr = 32'h00200093; @(posedge clk); #1;
        checkOutput("bp.ready2", 64'(in_ready), 64'd0);
        checkOutput("bp.hold1", 64'(out_imm), 64'd1);
        in_instr = 32'h00300093; @(posedge clk); #1;
        checkOutput("bp.ready3", 64'(in_ready), 64'd0);
        checkOutput("bp.hold2", 64'(out_imm), 64'd1);
        checkOutput("bp.valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1; @(posedge clk); #1;
        checkOutput("bp.second", 64'(out_imm), 64'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp.third", 64'(out_imm), 64'd3);
        checkOutput("bp.third.valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        checkOutput("bp.empty", 64'(out_valid), 64'd0);

        // Flush while FULL with an instruction presented in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; @(posedge clk); #1;
        in_instr = 32'h00200093; @(posedge clk); #1;
        checkOutput("fl.full", 64'(in_ready), 64'd0);
        in_instr = 32'h00700093; flush = 1'b1; @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checkOutput("fl.valid", 64'(out_valid), 64'd0);
        checkOutput("fl.ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1; @(posedge clk); #1;
        checkOutput("fl.nodrop", 64'(out_valid), 64'd0);
        applyStimulus(32'h00400093, 32'h0);
        checkOutput("fl.next", 64'(out_imm), 64'd4);

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("ar.before", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar.valid", 64'(out_valid), 64'd0);
        checkOutput("ar.ready", 64'(in_ready), 64'd1);
        checkOutput("ar.imm", 64'(out_imm), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
